// File: rtl/tp84_hiscore_arbiter.sv
// tp84_hiscore_arbiter
// Shares the TP84 main-board work RAM between the main CPU and the MiSTer
// hiscore port. A hiscore request halts the CPU at a bus-cycle boundary,
// hands the RAM port to the hiscore side, then gives it back.
// Build option: define TP84_HISCORE_EN to include the hand-over FSM. Without
// it the RAM is wired to the CPU permanently and cpu_halt only follows pause.
module tp84_hiscore_arbiter #(
  parameter int          ADDR_W  = 11,
  parameter logic [15:0] HS_BASE = 16'h0000
) (
  input  logic              clk_49m,
  input  logic              reset,
  input  logic              pause,
  input  logic              cpu_cen,
  input  logic              cpu_ram_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_halt,
  input  logic              hs_access,
  input  logic [15:0]       hs_address,
  input  logic [7:0]        hs_data_in,
  input  logic              hs_write,
  output logic [7:0]        hs_data_out,
  output logic              hs_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout
);

  // CPU write request that commits on this clock
  logic cpu_wr;
  assign cpu_wr = cpu_ram_cs & cpu_we & cpu_cen;

  // High for one cycle after every edge that samples reset low; it forces the
  // RAM port to zero so toggling CPU inputs cannot write during reset.
  logic rst_p1;

  // Track whether the last edge sampled reset asserted
  always_ff @(posedge clk_49m) begin
    rst_p1 <= ~reset;
  end

`ifdef TP84_HISCORE_EN

  typedef enum logic [1:0] {
    ST_CPU,
    ST_DRAIN,
    ST_HS,
    ST_RELEASE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        fair;
  logic [15:0] hs_off;
  logic        in_win;
  logic        hs_write_p1;
  logic        hs_we_p1;
  logic        in_win_p1;

  // Offset of a hiscore address inside the RAM window (16-bit wrap)
  function automatic logic [15:0] win_offset(input logic [15:0] addr);
    return addr - HS_BASE;
  endfunction

  // Window hit test; widened to 17 bits so ADDR_W=16 still works
  function automatic logic win_hit(input logic [15:0] off);
    return ({1'b0, off} < (17'd1 << ADDR_W));
  endfunction

  assign hs_off = win_offset(hs_address);
  assign in_win = win_hit(hs_off);

  // Next-state decode and RAM port mux
  always_comb begin
    state_nxt = state;
    ram_addr  = '0;
    ram_din   = 8'h00;
    ram_we    = 1'b0;
    hs_ready  = 1'b0;

    case (state)
      ST_CPU: begin
        if (hs_access && fair) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // An abandoned request wins over a coincident bus-cycle boundary
        if (!hs_access)   state_nxt = ST_CPU;
        else if (cpu_cen) state_nxt = ST_HS;
      end
      ST_HS: begin
        if (!hs_access) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_nxt = ST_CPU;
      end
      default: begin
        state_nxt = ST_CPU;
      end
    endcase

    if (!rst_p1) begin
      if (state == ST_HS) begin
        ram_addr = hs_off[ADDR_W-1:0];
        ram_din  = hs_data_in;
        ram_we   = hs_we_p1;
        hs_ready = 1'b1;
      end else begin
        // DRAIN keeps the CPU on the port so its in-flight write still lands
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = cpu_wr;
      end
    end
  end

  // State register and fairness flag
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      state <= ST_CPU;
      fair  <= 1'b1;
    end else begin
      state <= state_nxt;
      // A grant must be separated from the next by at least one CPU bus cycle
      if (state == ST_RELEASE)               fair <= 1'b0;
      else if (state == ST_CPU && cpu_cen)   fair <= 1'b1;
    end
  end

  // Registered halt: rises as soon as the FSM decides to leave CPU and falls
  // one cycle after it is back in CPU
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      cpu_halt <= 1'b0;
    end else begin
      cpu_halt <= pause | (state != ST_CPU) | (state_nxt != ST_CPU);
    end
  end

  // Hiscore write edge detect: one RAM write per rising edge of hs_write
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      hs_write_p1 <= 1'b0;
      hs_we_p1    <= 1'b0;
    end else begin
      hs_write_p1 <= hs_write;
      hs_we_p1    <= (state == ST_HS) & hs_access & hs_write & ~hs_write_p1 & in_win;
    end
  end

  // Read return: window flag follows the RAM read by one cycle, output is
  // registered and only refreshed while the hiscore side owns the RAM
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      in_win_p1   <= 1'b0;
      hs_data_out <= 8'h00;
    end else begin
      in_win_p1 <= in_win;
      if (state == ST_HS) hs_data_out <= in_win_p1 ? ram_dout : 8'hFF;
    end
  end

`else

  // Hiscore side is absent; these inputs are deliberately left unused
  logic unused_hs;
  assign unused_hs = ^{hs_access, hs_address, hs_data_in, hs_write, ram_dout, HS_BASE};

  assign hs_ready    = 1'b0;
  assign hs_data_out = 8'h00;

  // RAM port permanently on the CPU path
  always_comb begin
    ram_addr = '0;
    ram_din  = 8'h00;
    ram_we   = 1'b0;
    if (!rst_p1) begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = cpu_wr;
    end
  end

  // Registered pause-only halt
  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      cpu_halt <= 1'b0;
    end else begin
      cpu_halt <= pause;
    end
  end

`endif

endmodule

// File: tb/tb_tp84_hiscore_arbiter.sv
// Testbench for tp84_hiscore_arbiter: table-driven CPU-path vectors plus
// hand-written hand-over sequences (selected by TP84_HISCORE_EN).
module tb_tp84_hiscore_arbiter;

  logic        clk_49m = 1'b0;
  logic        reset;
  logic        pause;
  logic        cpu_cen;
  logic        cpu_ram_cs;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_halt;
  logic        hs_access;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write;
  logic [7:0]  hs_data_out;
  logic        hs_ready;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  logic [7:0]  mem [0:2047];

  int errs   = 0;
  int checks = 0;

  tp84_hiscore_arbiter #(.ADDR_W(11), .HS_BASE(16'h0000)) dut (
    .clk_49m     (clk_49m),
    .reset       (reset),
    .pause       (pause),
    .cpu_cen     (cpu_cen),
    .cpu_ram_cs  (cpu_ram_cs),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_halt    (cpu_halt),
    .hs_access   (hs_access),
    .hs_address  (hs_address),
    .hs_data_in  (hs_data_in),
    .hs_write    (hs_write),
    .hs_data_out (hs_data_out),
    .hs_ready    (hs_ready),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_dout    (ram_dout)
  );

  always #5 clk_49m = ~clk_49m;

  // Work RAM: synchronous write, 1-cycle synchronous read
  always @(posedge clk_49m) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    string       name;
    logic        pause;
    logic        cen;
    logic        cs;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  din;
    logic        exp_halt;
    logic        exp_we;
    logic [10:0] exp_addr;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input string n, input logic p, input logic cen,
                              input logic cs, input logic we, input logic [10:0] a,
                              input logic [7:0] d, input logic eh, input logic ew,
                              input logic [10:0] ea, input logic [7:0] ed);
    vec_t v;
    v.name = n; v.pause = p; v.cen = cen; v.cs = cs; v.we = we; v.addr = a;
    v.din = d; v.exp_halt = eh; v.exp_we = ew; v.exp_addr = ea; v.exp_din = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_49m);
    @(negedge clk_49m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    reset = 1'b0; pause = 1'b0; cpu_cen = 1'b0; cpu_ram_cs = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_din = '0; hs_access = 1'b0; hs_address = '0;
    hs_data_in = '0; hs_write = 1'b0;

    vecs[0] = mk("cpu_wr_5a",   0, 1, 1, 1, 11'h010, 8'h5A, 0, 1, 11'h010, 8'h5A);
    vecs[1] = mk("cpu_no_cen",  0, 0, 1, 1, 11'h010, 8'h5A, 0, 0, 11'h010, 8'h5A);
    vecs[2] = mk("pause_rd",    1, 1, 1, 0, 11'h010, 8'h00, 1, 0, 11'h010, 8'h00);
    vecs[3] = mk("no_cs",       0, 1, 0, 1, 11'h123, 8'h33, 0, 0, 11'h123, 8'h33);
    vecs[4] = mk("wr_top",      0, 1, 1, 1, 11'h7FF, 8'hC3, 0, 1, 11'h7FF, 8'hC3);
    vecs[5] = mk("cpu_rd",      0, 1, 1, 0, 11'h010, 8'h00, 0, 0, 11'h010, 8'h00);

    // Reset held 3 cycles with inputs toggling
    for (int i = 0; i < 3; i++) begin
      pause = 1'($urandom); cpu_cen = 1'($urandom); cpu_ram_cs = 1'b1; cpu_we = 1'b1;
      cpu_addr = 11'($urandom); cpu_din = 8'($urandom); hs_access = 1'($urandom);
      hs_address = 16'($urandom); hs_data_in = 8'($urandom); hs_write = 1'($urandom);
      tick();
      chk("rst_halt",  cpu_halt, 0);
      chk("rst_ready", hs_ready, 0);
      chk("rst_hsout", hs_data_out, 8'h00);
      chk("rst_we",    ram_we, 0);
      chk("rst_addr",  ram_addr, 0);
      chk("rst_din",   ram_din, 0);
    end

    reset = 1'b1; pause = 1'b0; cpu_cen = 1'b0; cpu_ram_cs = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_din = '0; hs_access = 1'b0; hs_address = '0;
    hs_data_in = '0; hs_write = 1'b0;
    tick();
    chk("rel_halt",  cpu_halt, 0);
    chk("rel_ready", hs_ready, 0);

    // CPU-path vector table
    for (int i = 0; i < 6; i++) begin
      pause = vecs[i].pause; cpu_cen = vecs[i].cen; cpu_ram_cs = vecs[i].cs;
      cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_din = vecs[i].din;
      tick();
      chk({vecs[i].name, "_halt"},  cpu_halt, vecs[i].exp_halt);
      chk({vecs[i].name, "_we"},    ram_we, vecs[i].exp_we);
      chk({vecs[i].name, "_addr"},  ram_addr, vecs[i].exp_addr);
      chk({vecs[i].name, "_din"},   ram_din, vecs[i].exp_din);
      chk({vecs[i].name, "_ready"}, hs_ready, 0);
      chk({vecs[i].name, "_hsout"}, hs_data_out, 8'h00);
    end
    cpu_cen = 1'b0;
    tick();
    chk("mem_010", mem[11'h010], 8'h5A);
    chk("mem_7ff", mem[11'h7FF], 8'hC3);

`ifdef TP84_HISCORE_EN
    // Hand-over: halt next cycle, grant after the next cpu_cen
    pause = 1'b0; cpu_ram_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h020; cpu_din = 8'h77;
    cpu_cen = 1'b0; hs_access = 1'b1; hs_address = 16'h0010; hs_data_in = 8'hA5;
    tick();
    chk("req_halt",  cpu_halt, 1);
    chk("req_ready", hs_ready, 0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (hs_ready !== 1'b0) n++;
    end
    chk("drain_ready_cnt", n, 0);
    cpu_cen = 1'b1;
    tick();
    cpu_cen = 1'b0;
    chk("grant_ready", hs_ready, 1);
    chk("grant_halt",  cpu_halt, 1);
    chk("drain_commit", mem[11'h020], 8'h77);

    // Held hs_write gives one RAM write; CPU write strobes are locked out
    hs_write = 1'b1;
    tick();
    chk("hs_we_first", ram_we, 1);
    chk("hs_we_addr",  ram_addr, 11'h010);
    chk("hs_we_din",   ram_din, 8'hA5);
    n = 1;
    for (int i = 1; i < 7; i++) begin
      cpu_cen = (i == 2 || i == 5);
      if (i == 5) hs_write = 1'b0;
      tick();
      if (ram_we === 1'b1) n++;
      if (hs_ready !== 1'b1) n += 100;
    end
    cpu_cen = 1'b0;
    chk("hs_we_count", n, 1);
    chk("hs_mem_010", mem[11'h010], 8'hA5);

    // Read latency: two cycles from address change
    hs_address = 16'h0000;
    tick(); tick();
    chk("rd_base", hs_data_out, 8'h00);
    hs_address = 16'h0010;
    tick();
    chk("rd_lat1", hs_data_out, 8'h00);
    tick();
    chk("rd_lat2", hs_data_out, 8'hA5);

    // Out-of-window write dropped, read returns FF
    hs_address = 16'h0800; hs_data_in = 8'h3C; hs_write = 1'b1;
    n = 0;
    tick(); if (ram_we === 1'b1) n++;
    tick(); if (ram_we === 1'b1) n++;
    chk("oow_rd", hs_data_out, 8'hFF);
    tick(); if (ram_we === 1'b1) n++;
    chk("oow_we_count", n, 0);
    chk("oow_mem_000", mem[11'h000], 8'h00);
    hs_write = 1'b0;

    // Release, re-raise in RELEASE: back to CPU, no DRAIN until a cpu_cen
    hs_access = 1'b0;
    tick();
    chk("rls_ready", hs_ready, 0);
    chk("rls_halt",  cpu_halt, 1);
    hs_access = 1'b1;
    tick();
    chk("back_halt",  cpu_halt, 1);
    chk("back_ready", hs_ready, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_halt !== 1'b0) n++;
    end
    chk("fair_hold_cnt", n, 0);
    cpu_cen = 1'b1;
    tick();
    chk("fair_cen_halt", cpu_halt, 0);
    cpu_cen = 1'b0;
    tick();
    chk("fair_drain_halt", cpu_halt, 1);
    // Abandon the request in DRAIN
    hs_access = 1'b0;
    tick();
    chk("abort_halt1", cpu_halt, 1);
    chk("abort_ready", hs_ready, 0);
    tick();
    chk("abort_halt0", cpu_halt, 0);

    // Pause together with a hiscore access
    pause = 1'b1; hs_access = 1'b1;
    tick();
    chk("pz_drain_halt", cpu_halt, 1);
    cpu_cen = 1'b1;
    tick();
    cpu_cen = 1'b0;
    chk("pz_hs_ready", hs_ready, 1);
    hs_access = 1'b0;
    tick();
    chk("pz_rls_ready", hs_ready, 0);
    tick();
    chk("pz_cpu_halt", cpu_halt, 1);
    tick();
    chk("pz_hold_halt", cpu_halt, 1);
    pause = 1'b0;
    tick();
    chk("pz_clear_halt", cpu_halt, 0);

    // Reset in the middle of HS discards a pending write edge
    cpu_cen = 1'b1;
    tick();
    cpu_cen = 1'b0; hs_access = 1'b1;
    tick();
    cpu_cen = 1'b1;
    tick();
    cpu_cen = 1'b0;
    chk("mid_ready", hs_ready, 1);
    hs_address = 16'h0030; hs_data_in = 8'hEE; hs_write = 1'b1; reset = 1'b0;
    tick();
    chk("mid_rst_ready", hs_ready, 0);
    chk("mid_rst_we",    ram_we, 0);
    chk("mid_rst_halt",  cpu_halt, 0);
    chk("mid_rst_hsout", hs_data_out, 8'h00);
    chk("mid_rst_addr",  ram_addr, 0);
    reset = 1'b1; hs_access = 1'b0;
    tick();
    chk("mid_post_we", ram_we, 0);
    tick();
    chk("mid_mem_030", mem[11'h030], 8'h00);
`else
    // Feature removed: hiscore ignored, RAM on the CPU, halt follows pause
    hs_access = 1'b1; hs_write = 1'b1; hs_address = 16'h0010; hs_data_in = 8'hEE;
    cpu_cen = 1'b0; cpu_ram_cs = 1'b0; cpu_we = 1'b0; cpu_addr = 11'h155; pause = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (hs_ready !== 1'b0) n++;
      hs_write = ~hs_write;
    end
    chk("dis_ready_cnt", n, 0);
    chk("dis_hsout", hs_data_out, 8'h00);
    chk("dis_we",    ram_we, 0);
    chk("dis_addr",  ram_addr, 11'h155);
    chk("dis_halt",  cpu_halt, 0);
    chk("dis_mem_010", mem[11'h010], 8'h5A);
    cpu_cen = 1'b1; cpu_ram_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h040; cpu_din = 8'h99;
    tick();
    chk("dis_cpu_we",   ram_we, 1);
    chk("dis_cpu_addr", ram_addr, 11'h040);
    cpu_cen = 1'b0;
    pause = 1'b1;
    #1;
    chk("dis_pause_pre", cpu_halt, 0);
    tick();
    chk("dis_pause_halt", cpu_halt, 1);
    chk("dis_mem_040", mem[11'h040], 8'h99);
    pause = 1'b0;
    tick();
    chk("dis_unpause", cpu_halt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
